// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the framed UART receiver.
// Holds the receiver state encoding, parity mode codes and bit-period calculation.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Clock cycles per bit, truncated.
    function automatic int sym_cycles(input int clk_frequency, input int baud_rate);
        return clk_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO for received frames: the head entry is visible while not empty.
// A push and a pop in the same cycle are both honoured even when full.
module uart_rx_fifo #(
    parameter int width = 10,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] wr_data,
    output logic [width-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int aw = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [aw:0]      wr_ptr_reg;
    logic [aw:0]      rd_ptr_reg;
    logic             wr_en;
    logic             rd_en;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[aw] != rd_ptr_reg[aw]) &&
                   (wr_ptr_reg[aw-1:0] == rd_ptr_reg[aw-1:0]);

    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    assign rd_data = mem[rd_ptr_reg[aw-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[aw-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_framed.sv
// Configurable UART receiver: data bits, parity and stop bits set by parameters.
// Frames land in a show-ahead FIFO with per-frame parity/framing flags.
module uart_rx_framed
    import uart_rx_pkg::*;
#(
    parameter int clk_frequency = 50_000_000,
    parameter int baud_rate     = 57600,
    parameter int data_bits     = 8,
    parameter int parity_mode   = 0,
    parameter int stop_bits     = 1,
    parameter int fifo_depth    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 rdy,
    output logic                 vld,
    output logic [data_bits-1:0] data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int sym = sym_cycles(clk_frequency, baud_rate);
    localparam int cw  = $clog2(sym + 1);
    localparam int fw  = data_bits + 2;

    localparam logic [cw-1:0] sym_load  = cw'(sym);
    localparam logic [cw-1:0] half_load = cw'(sym / 2);
    localparam logic [3:0]    last_data = 4'(data_bits - 1);
    localparam logic [3:0]    last_stop = 4'(stop_bits - 1);

    logic rx_meta_reg;
    logic rx_sync_reg;
    logic rx_prev_reg;

    rx_state_t              state_reg, state_next;
    logic [cw-1:0]          cnt_reg, cnt_next;
    logic [3:0]             bit_reg, bit_next;
    logic [data_bits-1:0]   shift_reg, shift_next;
    logic                   perr_reg, perr_next;
    logic                   ferr_reg, ferr_next;
    logic                   overrun_reg;

    logic                   tick;
    logic                   par_calc;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [fw-1:0]          head;

    assign tick     = (cnt_reg == cw'(1));
    assign par_calc = (^shift_reg) ^ rx_sync_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        perr_next  = perr_reg;
        ferr_next  = ferr_reg;
        push       = 1'b0;

        if (state_reg != IDLE) begin
            cnt_next = tick ? sym_load : cnt_reg - 1'b1;
        end

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (rx_prev_reg && !rx_sync_reg) begin
                    state_next = START;
                    cnt_next   = half_load;
                    perr_next  = 1'b0;
                    ferr_next  = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    // A high line at the start-bit centre was a glitch, not a frame.
                    if (rx_sync_reg) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        state_next = DATA;
                        bit_next   = '0;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_next = {rx_sync_reg, shift_reg[data_bits-1:1]};
                    if (bit_reg == last_data) begin
                        bit_next   = '0;
                        state_next = (parity_mode != PAR_NONE) ? PARITY : STOP;
                    end else begin
                        bit_next = bit_reg + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    perr_next  = (parity_mode == PAR_ODD) ? ~par_calc : par_calc;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    ferr_next = ferr_reg | ~rx_sync_reg;
                    if (bit_reg == last_stop) begin
                        push       = 1'b1;
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        bit_next = bit_reg + 4'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_reg     <= '0;
            shift_reg   <= '0;
            perr_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_reg     <= bit_next;
            shift_reg   <= shift_next;
            perr_reg    <= perr_next;
            ferr_reg    <= ferr_next;
            overrun_reg <= push && fifo_full && !pop;
        end
    end

    assign pop = vld && rdy;

    uart_rx_fifo #(
        .width (fw),
        .depth (fifo_depth)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data ({shift_reg, perr_reg, ferr_next}),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Head fields are forced to zero while empty so stale RAM never shows.
    always_comb begin
        vld        = !fifo_empty;
        data       = '0;
        parity_err = 1'b0;
        frame_err  = 1'b0;
        if (!fifo_empty) begin
            data       = head[fw-1:2];
            parity_err = head[1];
            frame_err  = head[0];
        end
    end

    assign overrun = overrun_reg;
    assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_framed.sv
// Scoreboard bench for uart_rx_framed: 8N1, 8E1 and 7O2 instances on separate lines.
// Stimulus pushes expected frames; a negedge monitor pops and compares on vld & rdy.
module tb_uart_rx_framed;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int SYM    = 10;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx_a = 1'b1, rx_e = 1'b1, rx_o = 1'b1;
    logic rdy_a = 1'b1, rdy_e = 1'b1, rdy_o = 1'b1;

    logic       vld_a, perr_a, ferr_a, ovr_a, busy_a;
    logic [7:0] data_a;
    logic       vld_e, perr_e, ferr_e, ovr_e, busy_e;
    logic [7:0] data_e;
    logic       vld_o, perr_o, ferr_o, ovr_o, busy_o;
    logic [6:0] data_o;

    exp_t q_a[$];
    exp_t q_e[$];
    exp_t q_o[$];
    exp_t e_a, e_e, e_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rise_a  = 0;
    int ovr_cnt_a = 0, ovr_cnt_e = 0, ovr_cnt_o = 0;
    logic vld_a_d = 1'b0;

    uart_rx_framed #(.clk_frequency(CLK_HZ), .baud_rate(BAUD), .data_bits(8),
                     .parity_mode(0), .stop_bits(1), .fifo_depth(4)) u_a (
        .clk(clk), .reset(reset), .rx(rx_a), .rdy(rdy_a), .vld(vld_a), .data(data_a),
        .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a), .busy(busy_a));

    uart_rx_framed #(.clk_frequency(CLK_HZ), .baud_rate(BAUD), .data_bits(8),
                     .parity_mode(1), .stop_bits(1), .fifo_depth(4)) u_e (
        .clk(clk), .reset(reset), .rx(rx_e), .rdy(rdy_e), .vld(vld_e), .data(data_e),
        .parity_err(perr_e), .frame_err(ferr_e), .overrun(ovr_e), .busy(busy_e));

    uart_rx_framed #(.clk_frequency(CLK_HZ), .baud_rate(BAUD), .data_bits(7),
                     .parity_mode(2), .stop_bits(2), .fifo_depth(4)) u_o (
        .clk(clk), .reset(reset), .rx(rx_o), .rdy(rdy_o), .vld(vld_o), .data(data_o),
        .parity_err(perr_o), .frame_err(ferr_o), .overrun(ovr_o), .busy(busy_o));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input logic [8:0] d, input logic p, input logic f);
        return {d, p, f};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic drive(input int d, input logic v);
        case (d)
            0: rx_a = v;
            1: rx_e = v;
            default: rx_o = v;
        endcase
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends start, data LSB first, optional parity bit (pbit < 0: none), stop bits.
    task automatic send(input int d, input logic [8:0] val, input int nbits,
                        input int pbit, input logic stop_v, input int nstop);
        logic [15:0] bits;
        int n;
        bits = '0;
        n = 1;
        for (int i = 0; i < nbits; i++) begin
            bits[n] = val[i];
            n++;
        end
        if (pbit >= 0) begin
            bits[n] = pbit[0];
            n++;
        end
        for (int i = 0; i < nstop; i++) begin
            bits[n] = stop_v;
            n++;
        end
        for (int i = 0; i < n; i++) begin
            drive(d, bits[i]);
            wait_cyc(SYM);
        end
    endtask

    // Monitor: one line per received frame, compared against the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            vld_a_d <= vld_a;
            if (vld_a && !vld_a_d) rise_a <= cyc;
            if (ovr_a) ovr_cnt_a++;
            if (ovr_e) ovr_cnt_e++;
            if (ovr_o) ovr_cnt_o++;
            if (vld_a && rdy_a) begin
                $display("[TB] A frame data=0x%0h perr=%0b ferr=%0b", data_a, perr_a, ferr_a);
                if (q_a.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("[TB] FAIL A_unexpected: got data 0x%0h, required no frame", data_a);
                end else begin
                    e_a = q_a.pop_front();
                    check("A_data", {24'd0, 1'b0, data_a}, {23'd0, e_a.data});
                    check("A_perr", perr_a, e_a.perr);
                    check("A_ferr", ferr_a, e_a.ferr);
                end
            end
            if (vld_e && rdy_e) begin
                $display("[TB] E frame data=0x%0h perr=%0b ferr=%0b", data_e, perr_e, ferr_e);
                if (q_e.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("[TB] FAIL E_unexpected: got data 0x%0h, required no frame", data_e);
                end else begin
                    e_e = q_e.pop_front();
                    check("E_data", {24'd0, 1'b0, data_e}, {23'd0, e_e.data});
                    check("E_perr", perr_e, e_e.perr);
                    check("E_ferr", ferr_e, e_e.ferr);
                end
            end
            if (vld_o && rdy_o) begin
                $display("[TB] O frame data=0x%0h perr=%0b ferr=%0b", data_o, perr_o, ferr_o);
                if (q_o.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("[TB] FAIL O_unexpected: got data 0x%0h, required no frame", data_o);
                end else begin
                    e_o = q_o.pop_front();
                    check("O_data", {25'd0, 2'b0, data_o}, {23'd0, e_o.data});
                    check("O_perr", perr_o, e_o.perr);
                    check("O_ferr", ferr_o, e_o.ferr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fall_cyc;
        int lat;
        logic [7:0] b77;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_vld", vld_a, 0);
        check("rst_data", data_a, 0);
        check("rst_perr", perr_a, 0);
        check("rst_ferr", ferr_a, 0);
        check("rst_overrun", ovr_a, 0);
        check("rst_busy", busy_a, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_cyc(5);

        // 1: 8N1 0xA5 with latency measurement
        q_a.push_back(mk(9'h0A5, 1'b0, 1'b0));
        fall_cyc = cyc;
        send(0, 9'h0A5, 8, -1, 1'b1, 1);
        wait_cyc(5);
        lat = rise_a - fall_cyc;
        check("T1_latency_95_99", (lat >= 95 && lat <= 99) ? 1 : 0, 1);

        // 2: parity, 8E1 (0x3C even bit is 0) and 7O2 (0x55 odd bit is 1)
        q_e.push_back(mk(9'h03C, 1'b1, 1'b0));
        send(1, 9'h03C, 8, 1, 1'b1, 1);
        q_e.push_back(mk(9'h03C, 1'b0, 1'b0));
        send(1, 9'h03C, 8, 0, 1'b1, 1);
        q_o.push_back(mk(9'h055, 1'b0, 1'b0));
        send(2, 9'h055, 7, 1, 1'b1, 2);
        q_o.push_back(mk(9'h055, 1'b1, 1'b0));
        send(2, 9'h055, 7, 0, 1'b1, 2);
        wait_cyc(10);

        // 3: false start, then a clean frame
        drive(0, 1'b0);
        wait_cyc(3);
        drive(0, 1'b1);
        @(negedge clk);
        check("T3_busy_during", busy_a, 1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("T3_busy_after", busy_a, 0);
        check("T3_no_vld", vld_a, 0);
        @(posedge clk);
        #1;
        q_a.push_back(mk(9'h012, 1'b0, 1'b0));
        send(0, 9'h012, 8, -1, 1'b1, 1);
        wait_cyc(10);

        // 4: bad stop bit followed by a break
        q_a.push_back(mk(9'h0FF, 1'b0, 1'b1));
        send(0, 9'h0FF, 8, -1, 1'b0, 1);
        wait_cyc(40);
        drive(0, 1'b1);
        wait_cyc(20);

        // 5: overrun with consumer stalled
        rdy_a = 1'b0;
        ovr_cnt_a = 0;
        for (int i = 1; i <= 4; i++) q_a.push_back(mk(9'(i), 1'b0, 1'b0));
        for (int i = 1; i <= 5; i++) send(0, 9'(i), 8, -1, 1'b1, 1);
        wait_cyc(20);
        @(negedge clk);
        check("T5_overrun_count", ovr_cnt_a, 1);
        check("T5_head_vld", vld_a, 1);
        check("T5_head_data", data_a, 8'h01);
        @(posedge clk);
        #1;
        rdy_a = 1'b1;
        wait_cyc(10);
        @(negedge clk);
        check("T5_drained_vld", vld_a, 0);
        @(posedge clk);
        #1;

        // 6: reset in the middle of data bit 3 of 0x77
        b77 = 8'h77;
        drive(0, 1'b0);
        wait_cyc(SYM);
        for (int i = 0; i < 3; i++) begin
            drive(0, b77[i]);
            wait_cyc(SYM);
        end
        drive(0, b77[3]);
        wait_cyc(3);
        @(negedge clk);
        check("T6_busy_before", busy_a, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(0, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("T6_busy_after_rst", busy_a, 0);
        check("T6_vld_after_rst", vld_a, 0);
        @(posedge clk);
        #1;
        wait_cyc(20);
        q_a.push_back(mk(9'h09A, 1'b0, 1'b0));
        send(0, 9'h09A, 8, -1, 1'b1, 1);
        wait_cyc(20);

        // All expected frames consumed, no stray overruns
        check("A_queue_empty", q_a.size(), 0);
        check("E_queue_empty", q_e.size(), 0);
        check("O_queue_empty", q_o.size(), 0);
        check("E_no_overrun", ovr_cnt_e, 0);
        check("O_no_overrun", ovr_cnt_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
